// File: rtl/register32_pkg.sv
// Shared width/reset defaults and the data type for the 32-bit storage register.
package register32_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] DATA_RESET = '0;

    typedef logic [DATA_WIDTH-1:0] data_t;

    // Even parity of a stored word: 1 when the word holds an odd number of ones.
    function automatic logic parity_of(input data_t value);
        return ^value;
    endfunction

endpackage

// File: rtl/register32.sv
// General-purpose storage register with load enable and synchronous clear (reset wins over writeEn).
// Optional macro REGISTER32_PARITY_EN adds a registered even-parity output alongside OUT.
module register32
    import register32_pkg::*;
#(
    parameter int               WIDTH       = DATA_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DATA_RESET)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             writeEn,
    input  logic [WIDTH-1:0] IN,
`ifdef REGISTER32_PARITY_EN
    output logic             parity,
`endif
    output logic [WIDTH-1:0] OUT
);

    always_ff @(posedge CLK) begin
        if (reset) begin
            OUT <= RESET_VALUE;
        end else if (writeEn) begin
            OUT <= IN;
        end
    end

`ifdef REGISTER32_PARITY_EN
    // Parity is computed from the value being loaded so it lands on the same edge as OUT.
    always_ff @(posedge CLK) begin
        if (reset) begin
            parity <= ^RESET_VALUE;
        end else if (writeEn) begin
            parity <= ^IN;
        end
    end
`endif

endmodule

// File: tb/tb_register32.sv
// Directed bench for register32: a cycle-level reference model plus hand-computed literal checks.
module tb_register32;

    localparam int W = 32;

    logic         CLK;
    logic         reset;
    logic         writeEn;
    logic [W-1:0] IN;
    logic [W-1:0] OUT;
`ifdef REGISTER32_PARITY_EN
    logic         parity;
`endif

    int checks = 0;
    int errors = 0;

    register32 dut (
        .CLK     (CLK),
        .reset   (reset),
        .writeEn (writeEn),
        .IN      (IN),
`ifdef REGISTER32_PARITY_EN
        .parity  (parity),
`endif
        .OUT     (OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: what the register must hold after each rising edge.
    logic [W-1:0] model_q;
    logic         model_known = 1'b0;

    always @(posedge CLK) begin
        if (reset === 1'b1) begin
            model_q     <= '0;
            model_known <= 1'b1;
        end else if (writeEn === 1'b1) begin
            model_q     <= IN;
            model_known <= 1'b1;
        end
    end

    // Continuous comparison on the falling edge, once the model holds a defined value.
    always @(negedge CLK) begin
        if (model_known) begin
            checks++;
            if (OUT !== model_q) begin
                errors++;
                $display("FAIL model_out: got %h expected %h at %0t", OUT, model_q, $time);
            end
`ifdef REGISTER32_PARITY_EN
            checks++;
            if (parity !== ^model_q) begin
                errors++;
                $display("FAIL model_parity: got %b expected %b at %0t", parity, ^model_q, $time);
            end
`endif
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_out(input string name, input logic [W-1:0] want);
        checks++;
        if (OUT !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, OUT, want);
        end
    endtask

    task automatic check_par(input string name, input logic want);
`ifdef REGISTER32_PARITY_EN
        checks++;
        if (parity !== want) begin
            errors++;
            $display("FAIL %s: parity got %b expected %b", name, parity, want);
        end
`else
        if (want === 1'bx) $display("parity unused");
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        writeEn = 1'b0;
        IN      = '0;
        step();
        check_out("reset_init", 32'd0);
        check_par("reset_init", 1'b0);

        reset   = 1'b0;
        writeEn = 1'b1;
        IN      = 32'h15;
        step();
        check_out("write_first", 32'd21);
        check_par("write_first", 1'b1);
        IN = 32'h1;
        #3;
        check_out("write_in_change", 32'd21);

        writeEn = 1'b0;
        IN      = 32'h7AA1;
        step();
        check_out("hold", 32'd21);

        writeEn = 1'b1;
        IN      = 32'h62A3;
        step();
        check_out("write_second", 32'd25251);
        check_par("write_second", 1'b1);

        reset   = 1'b1;
        writeEn = 1'b0;
        IN      = '0;
        step();
        check_out("reset_no_write", 32'd0);
        check_par("reset_no_write", 1'b0);

        writeEn = 1'b1;
        IN      = 32'hF;
        step();
        check_out("reset_priority", 32'd0);

        reset = 1'b0;
        step();
        check_out("write_after_reset", 32'd15);
        check_par("write_after_reset", 1'b0);

        // Every input wiggles between edges; only the values present at the edge matter.
        writeEn = 1'b0;
        #1 IN      = 32'hDEAD_BEEF;
        #1 writeEn = 1'b1;
        #1 writeEn = 1'b0;
        #1 reset   = 1'b1;
        #1 reset   = 1'b0;
        IN = 32'h1234;
        check_out("mid_cycle_pre", 32'd15);
        step();
        check_out("mid_cycle_post", 32'd15);

        writeEn = 1'b1;
        IN      = 32'hFFFF_FFFF;
        step();
        check_out("write_all_ones", 32'hFFFF_FFFF);
        check_par("write_all_ones", 1'b0);

        reset   = 1'b1;
        writeEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("reset_held", 32'd0);
        end

        reset   = 1'b0;
        writeEn = 1'b1;
        IN      = 32'hA5A5_0003;
        step();
        check_out("write_post_hold", 32'hA5A5_0003);
        check_par("write_post_hold", 1'b0);

        writeEn = 1'b0;
        IN      = 32'h8000_0000;
        step();
        check_out("hold_final", 32'hA5A5_0003);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
